// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control unit: state encodings,
// opcodes, ALU function selects and flag bit positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_FETCH_W = 4'd2,
        ST_DECODE  = 4'd3,
        ST_READ2   = 4'd4,
        ST_EXEC    = 4'd5,
        ST_WB      = 4'd6,
        ST_MEM_RD  = 4'd7,
        ST_MEM_WR  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_HALT    = 4'd10
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_NEG = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_BZ  = 4'hA;
    localparam logic [3:0] OP_BNZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] FS_ADD   = 3'd0;
    localparam logic [2:0] FS_SUB   = 3'd1;
    localparam logic [2:0] FS_AND   = 3'd2;
    localparam logic [2:0] FS_OR    = 3'd3;
    localparam logic [2:0] FS_NEG   = 3'd4;
    localparam logic [2:0] FS_CMP   = 3'd5;
    localparam logic [2:0] FS_MOV   = 3'd6;
    localparam logic [2:0] FS_PASSY = 3'd7;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier used by the control FSM to pick the
// second operand and the post-READ2 path.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_is_alu,
    output logic       o_has_wb,
    output logic       o_uses_rt,
    output logic       o_is_mem,
    output logic       o_is_br,
    output logic       o_illegal
);

    always_comb begin
        o_is_alu  = 1'b0;
        o_has_wb  = 1'b0;
        o_uses_rt = 1'b0;
        o_is_mem  = 1'b0;
        o_is_br   = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_is_alu  = 1'b1;
                o_has_wb  = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_NEG, OP_MOV: begin
                o_is_alu = 1'b1;
                o_has_wb = 1'b1;
            end
            OP_CMP: begin
                o_is_alu  = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_LD: begin
                o_is_mem = 1'b1;
                o_has_wb = 1'b1;
            end
            OP_ST: begin
                o_is_mem  = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_JMP, OP_BZ, OP_BNZ: o_is_br = 1'b1;
            OP_HLT: ;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller: state register, memory wait
// timeout, Z/C/V/S flags and the per-state strobe decode.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_ir,
    input  logic        i_mem_ready,
    input  logic        i_alu_z,
    input  logic        i_alu_c,
    input  logic        i_alu_v,
    input  logic        i_alu_s,
    output logic        o_pc_ld,
    output logic        o_pc_sel,
    output logic        o_ir_ld,
    output logic        o_x_ld,
    output logic        o_y_ld,
    output logic        o_addr_sel,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_rdr,
    output logic        o_wrr,
    output logic [2:0]  o_pa,
    output logic [2:0]  o_wp,
    output logic [2:0]  o_alu_fsel,
    output logic        o_alu_ld,
    output logic        o_wb_sel,
    output logic [3:0]  o_flags,
    output logic        o_halted,
    output logic        o_illegal,
    output logic        o_bus_err,
    output logic [3:0]  o_state
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic [3:0] r_flags;
    logic       r_bus_err;
    logic       w_timeout;
    logic       w_in_wait;
    logic       w_wait_last;

    logic [3:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic       w_is_alu;
    logic       w_has_wb;
    logic       w_uses_rt;
    logic       w_is_mem;
    logic       w_is_br;
    logic       w_illegal;

    assign w_op = i_ir[15:12];
    assign w_rd = i_ir[11:9];
    assign w_rs = i_ir[8:6];
    assign w_rt = i_ir[5:3];

    cpu_ctrl_decode u_decode (
        .i_op      (w_op),
        .o_is_alu  (w_is_alu),
        .o_has_wb  (w_has_wb),
        .o_uses_rt (w_uses_rt),
        .o_is_mem  (w_is_mem),
        .o_is_br   (w_is_br),
        .o_illegal (w_illegal)
    );

    assign w_in_wait   = (r_state == ST_FETCH_W) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    assign w_wait_last = (r_wait_cnt == 8'(WAIT_MAX - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_flags    <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_in_wait && !i_mem_ready)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_state == ST_EXEC) begin
                r_flags[FLAG_Z] <= i_alu_z;
                r_flags[FLAG_C] <= i_alu_c;
                r_flags[FLAG_V] <= i_alu_v;
                r_flags[FLAG_S] <= i_alu_s;
            end
            if (w_timeout)
                r_bus_err <= 1'b1;
            else if (((r_state == ST_IDLE) || (r_state == ST_HALT)) && i_start)
                r_bus_err <= 1'b0;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_timeout  = 1'b0;
        o_pc_ld    = 1'b0;
        o_pc_sel   = 1'b0;
        o_ir_ld    = 1'b0;
        o_x_ld     = 1'b0;
        o_y_ld     = 1'b0;
        o_addr_sel = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_wr   = 1'b0;
        o_rdr      = 1'b0;
        o_wrr      = 1'b0;
        o_pa       = 3'd0;
        o_wp       = 3'd0;
        o_alu_fsel = 3'd0;
        o_alu_ld   = 1'b0;
        o_wb_sel   = 1'b0;
        o_halted   = 1'b0;
        o_illegal  = 1'b0;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_FETCH;
            ST_FETCH: begin
                o_mem_rd = 1'b1;
                w_next   = ST_FETCH_W;
            end
            ST_FETCH_W: begin
                o_mem_rd = 1'b1;
                if (i_mem_ready) begin
                    o_ir_ld = 1'b1;
                    o_pc_ld = 1'b1;
                    w_next  = ST_DECODE;
                end else if (w_wait_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_HALT;
                end
            end
            ST_DECODE: begin
                o_rdr  = 1'b1;
                o_pa   = w_rs;
                o_x_ld = 1'b1;
                if (w_op == OP_HLT) begin
                    w_next = ST_HALT;
                end else if (w_illegal) begin
                    o_illegal = 1'b1;
                    w_next    = ST_FETCH;
                end else begin
                    w_next = ST_READ2;
                end
            end
            ST_READ2: begin
                o_rdr  = 1'b1;
                o_pa   = w_uses_rt ? w_rt : w_rs;
                o_y_ld = 1'b1;
                if (w_is_alu)
                    w_next = ST_EXEC;
                else if (w_is_mem)
                    w_next = (w_op == OP_LD) ? ST_MEM_RD : ST_MEM_WR;
                else if (w_is_br)
                    w_next = ST_BRANCH;
                else
                    w_next = ST_FETCH;
            end
            ST_EXEC: begin
                o_alu_ld   = 1'b1;
                o_alu_fsel = w_op[2:0];
                w_next     = w_has_wb ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                o_alu_ld   = 1'b1;
                o_alu_fsel = w_op[2:0];
                o_wrr      = 1'b1;
                o_wp       = w_rd;
                w_next     = ST_FETCH;
            end
            ST_MEM_RD: begin
                o_addr_sel = 1'b1;
                o_mem_rd   = 1'b1;
                if (i_mem_ready) begin
                    o_wrr    = 1'b1;
                    o_wp     = w_rd;
                    o_wb_sel = 1'b1;
                    w_next   = ST_FETCH;
                end else if (w_wait_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_HALT;
                end
            end
            ST_MEM_WR: begin
                // Store data travels through the ALU as a Y pass-through.
                o_addr_sel = 1'b1;
                o_mem_wr   = 1'b1;
                o_alu_fsel = FS_PASSY;
                o_alu_ld   = 1'b1;
                if (i_mem_ready) begin
                    w_next = ST_FETCH;
                end else if (w_wait_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_HALT;
                end
            end
            ST_BRANCH: begin
                if ((w_op == OP_JMP) || ((w_op == OP_BZ) && r_flags[FLAG_Z]) ||
                    ((w_op == OP_BNZ) && !r_flags[FLAG_Z])) begin
                    o_pc_ld  = 1'b1;
                    o_pc_sel = 1'b1;
                end
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                o_halted = 1'b1;
                if (i_start) w_next = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_flags   = r_flags;
    assign o_bus_err = r_bus_err;
    assign o_state   = r_state;

endmodule
